// File: rtl/vga_timing_param.sv
// Parametrised VGA raster controller: programmable h/v timing and sync polarity,
// pixel-request interface with configurable source latency, graceful stop, colour expansion.
module vga_timing_param #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 8,
  parameter int LAT      = 1
) (
  input  logic                   pixel_clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [3*COLOR_W-1:0]   pixel_in,
  output logic [15:0]            req_x,
  output logic [15:0]            req_y,
  output logic                   req_valid,
  output logic                   frame_start,
  output logic                   line_start,
  output logic [15:0]            frame_count,
  output logic [7:0]             vga_r,
  output logic [7:0]             vga_g,
  output logic [7:0]             vga_b,
  output logic                   vga_clk,
  output logic                   vga_blank_n,
  output logic                   vga_sync_n,
  output logic                   vga_hs,
  output logic                   vga_vs
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [15:0] H_LAST = 16'(H_TOT - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOT - 1);
  localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic HS_ON = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ON = (VS_POL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_STOP = 2'd2} state_t;

  state_t      state_r, state_nxt_s;
  logic [15:0] h_r, v_r, h_nxt_s, v_nxt_s, h_adv_s, v_adv_s;
  logic        wrap_s, run_nxt_s;
  logic        req_valid_r, frame_start_r, line_start_r, hs_req_r, vs_req_r;
  logic [15:0] frame_count_r;
  logic [LAT:0] hs_pipe_r, vs_pipe_r, act_pipe_r;
  logic        act_tap_s;
  logic [7:0]  vga_r_r, vga_g_r, vga_b_r;

  // Replicates the channel MSB-first until 8 bits are filled.
  function automatic logic [7:0] expand_f(input logic [COLOR_W-1:0] c);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) e[7-i] = c[COLOR_W-1-(i % COLOR_W)];
    return e;
  endfunction

  // Position the raster would move to on the next clock
  always_comb begin
    wrap_s = (h_r == H_LAST) && (v_r == V_LAST);
    if (h_r == H_LAST) begin
      h_adv_s = 16'd0;
      if (v_r == V_LAST) v_adv_s = 16'd0;
      else               v_adv_s = v_r + 16'd1;
    end else begin
      h_adv_s = h_r + 16'd1;
      v_adv_s = v_r;
    end
  end

  // Run-state transitions; a stop request only takes effect at the frame wrap
  always_comb begin
    state_nxt_s = state_r;
    h_nxt_s     = h_r;
    v_nxt_s     = v_r;
    case (state_r)
      ST_IDLE: begin
        h_nxt_s = 16'd0;
        v_nxt_s = 16'd0;
        if (enable) state_nxt_s = ST_RUN;
        else        state_nxt_s = ST_IDLE;
      end
      ST_RUN, ST_STOP: begin
        h_nxt_s = h_adv_s;
        v_nxt_s = v_adv_s;
        if (enable)      state_nxt_s = ST_RUN;
        else if (wrap_s) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_STOP;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        h_nxt_s     = 16'd0;
        v_nxt_s     = 16'd0;
      end
    endcase
    run_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // Request stage: counters, strobes and sync/active flags aligned to req_x/req_y
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      h_r           <= 16'd0;
      v_r           <= 16'd0;
      req_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      line_start_r  <= 1'b0;
      hs_req_r      <= 1'b0;
      vs_req_r      <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      state_r       <= state_nxt_s;
      h_r           <= h_nxt_s;
      v_r           <= v_nxt_s;
      req_valid_r   <= run_nxt_s && (h_nxt_s < H_ACT) && (v_nxt_s < V_ACT);
      frame_start_r <= run_nxt_s && (h_nxt_s == 16'd0) && (v_nxt_s == 16'd0);
      line_start_r  <= run_nxt_s && (h_nxt_s == 16'd0);
      hs_req_r      <= run_nxt_s && (h_nxt_s >= HS_BEG) && (h_nxt_s <= HS_END);
      vs_req_r      <= run_nxt_s && (v_nxt_s >= VS_BEG) && (v_nxt_s <= VS_END);
      if ((state_r != ST_IDLE) && wrap_s) frame_count_r <= frame_count_r + 16'd1;
    end
  end

  // Delay line carrying pin-level syncs and the active flag to the DAC stage
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_pipe_r  <= {(LAT+1){~HS_ON}};
      vs_pipe_r  <= {(LAT+1){~VS_ON}};
      act_pipe_r <= '0;
    end else begin
      hs_pipe_r[0]  <= hs_req_r ? HS_ON : ~HS_ON;
      vs_pipe_r[0]  <= vs_req_r ? VS_ON : ~VS_ON;
      act_pipe_r[0] <= req_valid_r;
      for (int i = 1; i <= LAT; i++) begin
        hs_pipe_r[i]  <= hs_pipe_r[i-1];
        vs_pipe_r[i]  <= vs_pipe_r[i-1];
        act_pipe_r[i] <= act_pipe_r[i-1];
      end
    end
  end

  // Active flag of the request whose pixel arrives on pixel_in this cycle
  generate
    if (LAT == 0) begin : g_tap_now
      assign act_tap_s = req_valid_r;
    end else begin : g_tap_pipe
      assign act_tap_s = act_pipe_r[LAT-1];
    end
  endgenerate

  // Colour register, forced black while blanked
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r_r <= 8'd0;
      vga_g_r <= 8'd0;
      vga_b_r <= 8'd0;
    end else if (act_tap_s) begin
      vga_r_r <= expand_f(pixel_in[3*COLOR_W-1 -: COLOR_W]);
      vga_g_r <= expand_f(pixel_in[2*COLOR_W-1 -: COLOR_W]);
      vga_b_r <= expand_f(pixel_in[COLOR_W-1:0]);
    end else begin
      vga_r_r <= 8'd0;
      vga_g_r <= 8'd0;
      vga_b_r <= 8'd0;
    end
  end

  assign req_x       = h_r;
  assign req_y       = v_r;
  assign req_valid   = req_valid_r;
  assign frame_start = frame_start_r;
  assign line_start  = line_start_r;
  assign frame_count = frame_count_r;
  assign vga_r       = vga_r_r;
  assign vga_g       = vga_g_r;
  assign vga_b       = vga_b_r;
  assign vga_hs      = hs_pipe_r[LAT];
  assign vga_vs      = vs_pipe_r[LAT];
  assign vga_blank_n = act_pipe_r[LAT];
  // DAC latches mid-cycle, so it runs on the inverted pixel clock
  assign vga_clk     = ~pixel_clk;
  assign vga_sync_n  = 1'b1;
endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: small-timing raster with LAT=2 checked cycle by cycle,
// plus a COLOR_W=3 / LAT=0 instance for colour expansion vectors.
module tb_vga_timing_param;
  localparam int HT = 14;      // 8+2+3+1
  localparam int VT = 8;       // 4+1+2+1
  localparam int FT = HT * VT; // clocks per frame
  localparam int PIPE = 3;     // LAT+1 for the first instance
  localparam int NEVER = 1000000;

  logic pixel_clk = 1'b0;
  logic rst_n1, rst_n2, enable1, enable2;
  logic [23:0] pixel1;
  logic [8:0]  pixel2;
  logic [23:0] pix_d1 = 24'd0, pix_d2 = 24'd0;

  logic [15:0] req_x1, req_y1, frame_count1, req_x2, req_y2, frame_count2;
  logic        req_valid1, frame_start1, line_start1, req_valid2, frame_start2, line_start2;
  logic [7:0]  vga_r1, vga_g1, vga_b1, vga_r2, vga_g2, vga_b2;
  logic        vga_clk1, vga_blank_n1, vga_sync_n1, vga_hs1, vga_vs1;
  logic        vga_clk2, vga_blank_n2, vga_sync_n2, vga_hs2, vga_vs2;

  int passed = 0;
  int total  = 0;

  always #5 pixel_clk = ~pixel_clk;

  // Pixel source for instance 1: returns {x, y, 0} two clocks after the request
  always @(posedge pixel_clk) begin
    pix_d1 <= {req_x1[7:0], req_y1[7:0], 8'h00};
    pix_d2 <= pix_d1;
  end
  assign pixel1 = pix_d2;

  vga_timing_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .COLOR_W(8), .LAT(2)
  ) u_dut1 (
    .pixel_clk(pixel_clk), .rst_n(rst_n1), .enable(enable1), .pixel_in(pixel1),
    .req_x(req_x1), .req_y(req_y1), .req_valid(req_valid1),
    .frame_start(frame_start1), .line_start(line_start1), .frame_count(frame_count1),
    .vga_r(vga_r1), .vga_g(vga_g1), .vga_b(vga_b1), .vga_clk(vga_clk1),
    .vga_blank_n(vga_blank_n1), .vga_sync_n(vga_sync_n1), .vga_hs(vga_hs1), .vga_vs(vga_vs1)
  );

  vga_timing_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .COLOR_W(3), .LAT(0)
  ) u_dut2 (
    .pixel_clk(pixel_clk), .rst_n(rst_n2), .enable(enable2), .pixel_in(pixel2),
    .req_x(req_x2), .req_y(req_y2), .req_valid(req_valid2),
    .frame_start(frame_start2), .line_start(line_start2), .frame_count(frame_count2),
    .vga_r(vga_r2), .vga_g(vga_g2), .vga_b(vga_b2), .vga_clk(vga_clk2),
    .vga_blank_n(vga_blank_n2), .vga_sync_n(vga_sync_n2), .vga_hs(vga_hs2), .vga_vs(vga_vs2)
  );

  typedef struct packed {
    logic [15:0] rx, ry;
    logic        rv, fs, ls;
    logic [15:0] fc;
    logic [7:0]  r, g, b;
    logic        blank_n, hs, vs, sync_n, vclk;
  } obs_t;

  typedef struct {
    logic       active;
    logic [8:0] pix;
    logic [7:0] r, g, b;
  } cvec_t;

  // Expected instance-1 outputs n cycles after the run began (n<0: idle);
  // the raster runs for cycles [0, stop_n).
  function automatic obs_t exp_obs(int n, int stop_n, int fc_base);
    obs_t e;
    bit run, run_o;
    int h, v, m, ho, vo, done;
    e = '0;
    run = (n >= 0) && (n < stop_n);
    h = run ? n % HT : 0;
    v = run ? (n / HT) % VT : 0;
    e.rx = 16'(h);
    e.ry = 16'(v);
    e.rv = run && (h < 8) && (v < 4);
    e.fs = run && (h == 0) && (v == 0);
    e.ls = run && (h == 0);
    m = n - PIPE;
    run_o = (m >= 0) && (m < stop_n);
    ho = run_o ? m % HT : 0;
    vo = run_o ? (m / HT) % VT : 0;
    e.blank_n = run_o && (ho < 8) && (vo < 4);
    e.hs = run_o && (ho >= 10) && (ho <= 12);
    e.vs = run_o && (vo >= 5) && (vo <= 6);
    e.r = e.blank_n ? 8'(ho) : 8'd0;
    e.g = e.blank_n ? 8'(vo) : 8'd0;
    e.b = 8'd0;
    done = (n > 0) ? ((n < stop_n ? n : stop_n) / FT) : 0;
    e.fc = 16'(fc_base + done);
    e.sync_n = 1'b1;
    e.vclk = 1'b1;
    return e;
  endfunction

  function automatic obs_t sample1();
    obs_t a;
    a = {req_x1, req_y1, req_valid1, frame_start1, line_start1, frame_count1,
         vga_r1, vga_g1, vga_b1, vga_blank_n1, vga_hs1, vga_vs1, vga_sync_n1, vga_clk1};
    return a;
  endfunction

  task automatic check_obs(input string name, input int n, input obs_t e);
    obs_t a;
    a = sample1();
    total++;
    if (a !== e) $display("FAIL %s n=%0d got=%h expected=%h", name, n, a, e);
    else passed++;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s got=%h expected=%h", name, act, exp);
    else passed++;
  endtask

  task automatic run_check(input string name, input int ncyc, input int stop_n,
                           input int drop_at, input int fc_base);
    for (int n = 0; n < ncyc; n++) begin
      @(negedge pixel_clk);
      check_obs(name, n, exp_obs(n, stop_n, fc_base));
      if (n == drop_at) enable1 = 1'b0;
    end
  endtask

  cvec_t cv[6];
  bit    found, pos_ok;

  initial begin
    cv[0] = '{1'b1, 9'b101_011_111, 8'hB6, 8'h6D, 8'hFF};
    cv[1] = '{1'b1, 9'b000_000_000, 8'h00, 8'h00, 8'h00};
    cv[2] = '{1'b1, 9'b111_000_100, 8'hFF, 8'h00, 8'h92};
    cv[3] = '{1'b1, 9'b010_110_001, 8'h49, 8'hDB, 8'h24};
    cv[4] = '{1'b0, 9'b111_111_111, 8'h00, 8'h00, 8'h00};
    cv[5] = '{1'b0, 9'b101_011_111, 8'h00, 8'h00, 8'h00};

    rst_n1 = 1'b0; rst_n2 = 1'b0; enable1 = 1'b0; enable2 = 1'b0; pixel2 = 9'd0;
    repeat (2) @(negedge pixel_clk);
    check_obs("reset", -100, exp_obs(-100, NEVER, 0));
    check_val("reset_idle2", {29'd0, vga_hs2, vga_vs2, vga_blank_n2}, 32'd6);
    rst_n1 = 1'b1; rst_n2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge pixel_clk);
      check_obs("idle_hold", -100, exp_obs(-100, NEVER, 0));
    end
    check_val("idle_low_pol2", {29'd0, vga_hs2, vga_vs2, vga_blank_n2}, 32'd6);

    // Colour expansion, COLOR_W=3 with zero source latency
    enable2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      found = 1'b0;
      for (int w = 0; w < 200 && !found; w++) begin
        @(negedge pixel_clk);
        if (req_valid2 == cv[i].active) found = 1'b1;
      end
      if (!found) begin
        total++;
        $display("FAIL color_wait vec=%0d got=timeout expected=req_valid %0b", i, cv[i].active);
      end else begin
        pos_ok = (((req_x2 < 16'd8) && (req_y2 < 16'd4)) == req_valid2) &&
                 (line_start2 == (req_x2 == 16'd0)) &&
                 (!frame_start2 || (req_y2 == 16'd0)) && (frame_count2 < 16'd50);
        pixel2 = cv[i].pix;
        @(negedge pixel_clk);
        total++;
        if ({vga_r2, vga_g2, vga_b2, vga_blank_n2, vga_sync_n2, vga_clk2, pos_ok} !==
            {cv[i].r, cv[i].g, cv[i].b, cv[i].active, 1'b1, 1'b1, 1'b1})
          $display("FAIL color vec=%0d got=%h_%h_%h blank_n=%0b pos=%0b expected=%h_%h_%h blank_n=%0b",
                   i, vga_r2, vga_g2, vga_b2, vga_blank_n2, pos_ok,
                   cv[i].r, cv[i].g, cv[i].b, cv[i].active);
        else passed++;
      end
    end

    // Two full frames, then drop enable at (3,2) of the third frame
    @(negedge pixel_clk);
    enable1 = 1'b1;
    run_check("raster", 3 * FT + 14, 3 * FT, 2 * FT + 2 * HT + 3, 0);

    // Restart: frame_start on the first cycle after enable is sampled
    @(negedge pixel_clk);
    enable1 = 1'b1;
    run_check("restart", 20, NEVER, -1, 3);

    // Asynchronous reset between edges at (5,1)
    #2 rst_n1 = 1'b0;
    #1 check_obs("async_rst", -100, exp_obs(-100, NEVER, 0));
    @(negedge pixel_clk);
    check_obs("rst_hold", -100, exp_obs(-100, NEVER, 0));
    rst_n1 = 1'b1;
    run_check("after_rst", FT, NEVER, -1, 0);

    // frame_count wrap from 16'hFFFF
    force u_dut1.frame_count_r = 16'hFFFF;
    #1 release u_dut1.frame_count_r;
    check_val("fc_preload", {16'd0, frame_count1}, 32'h0000FFFF);
    @(negedge pixel_clk);
    check_val("fc_wrap", {15'd0, frame_start1, frame_count1}, 32'h00010000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vga_timing_param.md
Name: vga_timing_param

Overview:
- Parametrised VGA raster controller; next generation of the fixed 640x480 `vga` block.
- Generates programmable h/v timing with per-axis sync polarity and a pixel-request interface with configurable pixel-source latency.
- Adds enable/graceful stop, color-depth expansion to the 8-bit DAC, and frame/line strobes.
- Sits between the screen renderer (pixel source) and the board VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, asserted level of vga_hs (0 = active-low)
- VS_POL, 0, asserted level of vga_vs
- COLOR_W, 8, bits per channel on pixel_in (1..8)
- LAT, 1, pixel-source latency in clocks (0..4)

Ports:
- pixel_clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run raster; low = stop at end of frame
- pixel_in  in  3*COLOR_W  {r,g,b} for request issued LAT cycles earlier
- req_x  out  16  requested column
- req_y  out  16  requested row
- req_valid  out  1  req_x/req_y inside active area while running
- frame_start  out  1  1-cycle pulse at counter (0,0) while running
- line_start  out  1  1-cycle pulse at h=0 while running
- frame_count  out  16  completed frames, wraps
- vga_r, vga_g, vga_b  out  8 each  DAC color
- vga_clk  out  1  ~pixel_clk (DAC samples mid-cycle)
- vga_blank_n  out  1  low outside active area
- vga_sync_n  out  1  constant 1
- vga_hs, vga_vs  out  1  syncs, polarity per parameter

Behaviour:
- H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise. Counters h 0..H_TOT-1, v 0..V_TOT-1; h wraps to 0 and increments v; v wraps at V_TOT-1 with h=H_TOT-1.
- States:
  - IDLE: counters held at (0,0); req_valid=0; strobes 0; vga color 0; blank_n=0; hs/vs deasserted. enable=1 sampled -> RUN.
  - RUN: count every clock. enable=0 -> STOPPING.
  - STOPPING: count until frame wrap, then IDLE. If enable returns to 1 before the wrap -> RUN, with no break in timing.
- Request stage (registered): req_x/req_y equal (h,v) of the current clock's counter; req_valid = h<H_ACTIVE && v<V_ACTIVE.
- Output stage: timing for request cycle k appears on vga_* at cycle k+LAT+1.
  - hs/vs/blank are delayed through a LAT+1-deep shift register.
  - Color register loads pixel_in at the edge ending cycle k+LAT.
  - Color is forced to 0 when the delayed blank is active.
- Sync timing:
  - hs asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- Color expansion: each channel output = top 8 bits of the channel value concatenated with itself repeatedly. COLOR_W=8 passes through; COLOR_W=3, value 3'b101 -> 8'b10110110.
- frame_count increments on the clock where v/h wrap to (0,0). Wraps 16'hFFFF -> 0.
- Reset (async, any time, including mid-frame):
  - State -> IDLE; counters, pipeline and frame_count -> 0.
  - Outputs as in IDLE.
  - vga_sync_n = 1; vga_clk continues to follow ~pixel_clk.
- Reset release: no output activity until enable is sampled high.
- LAT=0: pixel_in is sampled in the same cycle as its request.

Test Plan:
- Defaults, enable held 1 for 2 frames:
  - hs period 800 clks; hs low for 96 clks starting 656 clks after its line's h=0 (+LAT+1 pipe).
  - vs low for exactly 2 lines per 525.
  - blank_n high 640 clks per line on 480 lines; frame_count = 2.
- Small timing H=8/2/3/1, V=4/1/2/1, HS_POL=VS_POL=1, LAT=2, pixel_in = {req_x,req_y,0} fed through a 2-stage delay:
  - Every blank_n-high cycle shows vga_r=x, vga_g=y, matching the raster position.
  - hs high exactly 3 of every 14 clocks.
- COLOR_W=3, pixel_in = 9'b101_011_111 constant -> vga_r=8'hB6, vga_g=8'h6D, vga_b=8'hFF in active area; 0 while blanked.
- Drop enable at mid-frame, (h,v)=(100,200):
  - Raster completes the frame; req_valid stays 0 after the wrap.
  - frame_count +1; no further strobes.
  - Re-raise enable: frame_start pulses on the next cycle after sampling.
- Assert rst_n=0 asynchronously mid-line at (h,v)=(300,100), between clock edges:
  - All outputs go to reset values immediately, before the next edge; frame_count=0.
  - After release with enable=1, first frame_start is 1 cycle after the enable sample.
- frame_count preloaded near wrap (force to 16'hFFFF via long run or bench force) -> next wrap gives 0.
